dac_scan_sequencer: RTL and testbench

Upstream sequencer for the MCP4921 SPI DAC stage. Steps a 12-bit DAC code from a programmed start value to a stop value in fixed increments. For each point it presents the code, pulses `start_step` to launch the SPI frame, and waits for the frame-complete handshake. It then holds a measurement gate for a programmed dwell and reports the finished point to the counter/readout logic.

---
 rtl/dac_scan_sequencer.sv | 172 +++++++++++++++++
 tb/tb_dac_scan_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_scan_sequencer.sv
// dac_scan_sequencer
//   Steps a DAC code from code_start to code_stop (inclusive) in code_step
//   increments. Each point: present code + start_step pulse, wait for
//   dac_done (with timeout), hold meas_gate for the dwell, then pulse
//   point_valid. A normal finish pulses done; a bad range or a timeout sets
//   the sticky err, which the next accepted start clears.
// Ports:
//   clk, nres            clock, synchronous active-low reset
//   start, abort         launch (IDLE only) / terminate (any state)
//   code_start/stop/step scan range and increment (latched on start)
//   dwell                gate length per point (0 behaves as 1)
//   dac_done             SPI frame loaded handshake
//   dac_code, start_step code to DAC and frame-launch pulse
//   meas_gate            high during dwell
//   point_valid          pulse after each dwell; point_index = current point
//   busy, done, err      status
module dac_scan_sequencer #(
  parameter int CODE_WIDTH  = 12,
  parameter int DWELL_WIDTH = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   nres,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CODE_WIDTH-1:0]  code_start,
  input  logic [CODE_WIDTH-1:0]  code_stop,
  input  logic [CODE_WIDTH-1:0]  code_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic                   dac_done,
  output logic [CODE_WIDTH-1:0]  dac_code,
  output logic                   start_step,
  output logic                   meas_gate,
  output logic                   point_valid,
  output logic [15:0]            point_index,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DAC, DWELL, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CODE_WIDTH-1:0]  code_q, code_d;
  logic [CODE_WIDTH-1:0]  stop_q, stop_d;
  logic [CODE_WIDTH-1:0]  step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_cfg_q, dwell_cfg_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [15:0]            idx_q, idx_d;
  logic                   err_q, err_d;
  logic                   start_step_q, start_step_d;
  logic                   point_valid_q, point_valid_d;
  logic                   done_q, done_d;
  logic [CODE_WIDTH:0]    next_code;

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    stop_d        = stop_q;
    step_d        = step_q;
    dwell_cfg_d   = dwell_cfg_q;
    dwell_cnt_d   = dwell_cnt_q;
    tmo_d         = tmo_q;
    idx_d         = idx_q;
    err_d         = err_q;
    start_step_d  = 1'b0;
    point_valid_d = 1'b0;
    done_d        = 1'b0;
    // extra top bit catches overflow past the code range
    next_code     = {1'b0, code_q} + {1'b0, step_q};

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (code_start > code_stop) begin
              err_d = 1'b1;
            end else begin
              stop_d       = code_stop;
              step_d       = code_step;
              dwell_cfg_d  = dwell;
              code_d       = code_start;
              idx_d        = '0;
              err_d        = 1'b0;
              tmo_d        = '0;
              start_step_d = 1'b1;
              state_d      = WAIT_DAC;
            end
          end
        end
        WAIT_DAC: begin
          if (dac_done) begin
            dwell_cnt_d = (dwell_cfg_q == '0) ? DWELL_WIDTH'(1) : dwell_cfg_q;
            state_d     = DWELL;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        DWELL: begin
          if (dwell_cnt_q == DWELL_WIDTH'(1)) begin
            point_valid_d = 1'b1;
            if (step_q == '0 || next_code[CODE_WIDTH] ||
                next_code[CODE_WIDTH-1:0] > stop_q) begin
              state_d = DONE;
            end else begin
              code_d       = next_code[CODE_WIDTH-1:0];
              idx_d        = (idx_q == '1) ? idx_q : idx_q + 16'd1;
              tmo_d        = '0;
              start_step_d = 1'b1;
              state_d      = WAIT_DAC;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nres) begin
      state_q       <= IDLE;
      code_q        <= '0;
      stop_q        <= '0;
      step_q        <= '0;
      dwell_cfg_q   <= '0;
      dwell_cnt_q   <= '0;
      tmo_q         <= '0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      start_step_q  <= 1'b0;
      point_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      stop_q        <= stop_d;
      step_q        <= step_d;
      dwell_cfg_q   <= dwell_cfg_d;
      dwell_cnt_q   <= dwell_cnt_d;
      tmo_q         <= tmo_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      start_step_q  <= start_step_d;
      point_valid_q <= point_valid_d;
      done_q        <= done_d;
    end
  end

  assign dac_code    = code_q;
  assign start_step  = start_step_q;
  assign meas_gate   = (state_q == DWELL);
  assign point_valid = point_valid_q;
  assign point_index = idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dac_scan_sequencer.sv
module tb_dac_scan_sequencer;

  logic        clk = 1'b0;
  logic        nres;
  logic        start;
  logic        abort;
  logic [11:0] code_start;
  logic [11:0] code_stop;
  logic [11:0] code_step;
  logic [15:0] dwell;
  logic        dac_done;
  logic [11:0] dac_code;
  logic        start_step;
  logic        meas_gate;
  logic        point_valid;
  logic [15:0] point_index;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  dac_scan_sequencer #(
    .CODE_WIDTH (12),
    .DWELL_WIDTH(16),
    .TIMEOUT    (1024)
  ) dut (
    .clk        (clk),
    .nres       (nres),
    .start      (start),
    .abort      (abort),
    .code_start (code_start),
    .code_stop  (code_stop),
    .code_step  (code_step),
    .dwell      (dwell),
    .dac_done   (dac_done),
    .dac_code   (dac_code),
    .start_step (start_step),
    .meas_gate  (meas_gate),
    .point_valid(point_valid),
    .point_index(point_index),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the cycle where start_step is high for this point; dac_done is
  // returned 5 cycles later. Non-last points leave the bench in the next
  // point's start_step cycle; the last point runs through done.
  task automatic run_point(input logic [11:0] code, input logic [15:0] idx,
                           input int dw, input bit last);
    chk("step_pulse", start_step, 1);
    chk("code", dac_code, code);
    chk("index", point_index, idx);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("step_low", start_step, 0);
      chk("gate_wait", meas_gate, 0);
    end
    tick();
    dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
    for (int i = 0; i < dw; i++) begin
      chk("gate_high", meas_gate, 1);
      chk("code_hold", dac_code, code);
      chk("pv_low", point_valid, 0);
      tick();
    end
    chk("gate_fall", meas_gate, 0);
    chk("pv_pulse", point_valid, 1);
    if (last) begin
      chk("no_step_last", start_step, 0);
      chk("busy_pv", busy, 1);
      tick();
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("pv_off", point_valid, 0);
      chk("last_code", dac_code, code);
      tick();
      chk("done_off", done, 0);
    end
  endtask

  task automatic launch(input logic [11:0] s, input logic [11:0] e,
                        input logic [11:0] st, input logic [15:0] dw);
    code_start = s;
    code_stop  = e;
    code_step  = st;
    dwell      = dw;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  initial begin
    nres = 1'b0; start = 1'b0; abort = 1'b0; dac_done = 1'b0;
    code_start = '0; code_stop = '0; code_step = '0; dwell = '0;
    tick();
    tick();
    chk("rst_code", dac_code, 0);
    chk("rst_index", point_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {start_step, meas_gate, point_valid, done, err}, 0);
    nres = 1'b1;
    tick();

    // Basic scan; config changes after launch must be ignored.
    launch(12'h100, 12'h104, 12'h002, 16'd3);
    chk("busy_start", busy, 1);
    code_stop = 12'h000;
    code_step = 12'h001;
    dwell     = 16'd9;
    run_point(12'h100, 16'd0, 3, 1'b0);
    run_point(12'h102, 16'd1, 3, 1'b0);
    run_point(12'h104, 16'd2, 3, 1'b1);

    // Next code would overflow 12 bits: single point.
    launch(12'hFF0, 12'hFFF, 12'h020, 16'd2);
    run_point(12'hFF0, 16'd0, 2, 1'b1);

    // Step of zero: single point.
    launch(12'h200, 12'h300, 12'h000, 16'd2);
    run_point(12'h200, 16'd0, 2, 1'b1);

    // Bad range.
    launch(12'h300, 12'h200, 12'h001, 16'd1);
    chk("bad_err", err, 1);
    chk("bad_step", start_step, 0);
    chk("bad_busy", busy, 0);
    tick();
    chk("bad_busy2", busy, 0);
    chk("bad_err_hold", err, 1);

    // Valid start clears err; dwell of zero gives a one-cycle gate.
    launch(12'h010, 12'h011, 12'h001, 16'd0);
    chk("err_clr", err, 0);
    run_point(12'h010, 16'd0, 1, 1'b0);
    run_point(12'h011, 16'd1, 1, 1'b1);

    // Timeout: err exactly 1024 cycles after start_step.
    launch(12'h050, 12'h060, 12'h001, 16'd1);
    chk("tmo_step", start_step, 1);
    for (int i = 1; i < 1024; i++) begin
      tick();
      if (err !== 1'b0 || busy !== 1'b1) chk("tmo_early", {err, busy}, 2'b01);
    end
    chk("tmo_pre_err", err, 0);
    chk("tmo_pre_busy", busy, 1);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_done", done, 0);
    tick();
    chk("tmo_done2", done, 0);

    // Abort mid-dwell at point 1.
    launch(12'h100, 12'h104, 12'h002, 16'd3);
    run_point(12'h100, 16'd0, 3, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
    chk("ab_gate_on", meas_gate, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_gate", meas_gate, 0);
    chk("ab_busy", busy, 0);
    chk("ab_code", dac_code, 12'h102);
    chk("ab_index", point_index, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_no_pv", {point_valid, done, start_step}, 0);
    end

    // start and abort together in IDLE: abort wins.
    code_start = 12'h020; code_stop = 12'h030; code_step = 12'h001; dwell = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_step", start_step, 0);
    chk("sa_code", dac_code, 12'h102);

    // Reset in WAIT_DAC, then a late dac_done is ignored.
    launch(12'h040, 12'h050, 12'h004, 16'd2);
    tick();
    chk("rs_wait", busy, 1);
    nres = 1'b0;
    tick();
    nres = 1'b1;
    chk("rs_code", dac_code, 0);
    chk("rs_index", point_index, 0);
    chk("rs_busy", busy, 0);
    chk("rs_flags", {start_step, meas_gate, point_valid, done, err}, 0);
    dac_done = 1'b1;
    tick();
    dac_done = 1'b0;
    chk("late_gate", meas_gate, 0);
    chk("late_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
